// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with registered grant outputs and one idle cycle between grants.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles and pulse timeout.
module round_robin_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    logic       hold_limit;

    assign hold_limit = (hold_q == 8'(MAX_HOLD - 1));
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (found) begin
                    state_d     = GRANT;
                    gnt_id_d    = pick;
                    gnt_d       = 4'b0001 << pick;
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = '0;
`endif
                end
            end
            default: begin
                if (done || !req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_limit) begin
                    // Forced release only when the owner did not release on its own this cycle.
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + 2'd1;
                    timeout_d   = 1'b1;
                end else begin
                    hold_d      = hold_q + 8'd1;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^8'(MAX_HOLD);
    assign timeout         = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: per-cycle model comparison plus directed scenarios with literal expectations.
// Expectations for the hold-limit scenario follow whether ARB_TIMEOUT_EN is defined.
module tb_round_robin_arbiter;

    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    round_robin_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = nobody), rotating start index, cycles owned so far.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    int   m_last  = 0;
    bit   m_tout  = 1'b0;

    always @(posedge clk) begin
        m_tout = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_last  = m_owner;
                    m_held  = 1;
                end
            end
        end else if (done || !req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
`ifdef ARB_TIMEOUT_EN
        end else if (m_held == HOLD) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_tout  = 1'b1;
`endif
        end else begin
            m_held++;
        end
        #1;
        chk("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("model_gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_gnt_id", 32'(gnt_id), 32'(m_last));
        chk("model_timeout", 32'(timeout), 32'(m_tout));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic [3:0] exp, input string name);
        int n = 0;
        while (gnt_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({name, "_gnt"}, 32'(gnt), 32'(exp));
        chk({name, "_idle_gap"}, 32'(n), 32'd1);
    endtask

    task automatic do_release(input logic [3:0] next_req, input string name);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = next_req;
        chk({name, "_released"}, 32'(gnt_valid), 32'd0);
        chk({name, "_gnt_zero"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        logic [3:0] seq [5];
        int n;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        #3 rst = 1'b1;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        req = 4'b1111;

        // Full rotation with done two cycles into each grant.
        for (int g = 0; g < 5; g++) begin
            wait_grant(seq[g], $sformatf("rot%0d", g));
            tick();
            tick();
            do_release((g == 4) ? 4'b0010 : 4'b1111, $sformatf("rot%0d", g));
        end

        // Owner 1 releases -> ptr 2; requests 0 and 1 wrap to 0.
        wait_grant(4'b0010, "own1");
        do_release(4'b0011, "own1");
        wait_grant(4'b0001, "wrap0");
        chk("wrap0_id", 32'(gnt_id), 32'd0);
        do_release(4'b1111, "wrap0");
        wait_grant(4'b0010, "ptr1");

        // Non-owner request during grant must not preempt.
        req = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold1_gnt", 32'(gnt), 32'b0010);
        end
        do_release(4'b1010, "hold1");
        wait_grant(4'b1000, "after1");

        // Owner 2 drops its request without done.
        do_release(4'b0100, "own3");
        wait_grant(4'b0100, "own2");
        tick();
        req = 4'b0000;
        tick();
        chk("drop2_valid", 32'(gnt_valid), 32'd0);
        req = 4'b1001;
        wait_grant(4'b1000, "ptr3");

        // Asynchronous reset mid-grant.
        do_release(4'b0100, "pre_rst");
        wait_grant(4'b0100, "pre_rst2");
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_valid", 32'(gnt_valid), 32'd0);
        chk("async_rst_id", 32'(gnt_id), 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b0101;
        wait_grant(4'b0001, "post_rst");

        // done while idle is ignored.
        do_release(4'b0000, "idle_done");
        done = 1'b1;
        tick();
        tick();
        chk("idle_done_valid", 32'(gnt_valid), 32'd0);
        done = 1'b0;
        req  = 4'b0100;
        wait_grant(4'b0100, "after_idle");

        // Long hold by requester 0.
        do_release(4'b0001, "pre_hold");
        wait_grant(4'b0001, "long_hold");
        n = 0;
        while (gnt_valid === 1'b1 && n < 20) begin
            chk("hold_no_timeout", 32'(timeout), 32'd0);
            n++;
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        chk("hold_cycles", 32'(n), 32'(HOLD));
        chk("timeout_pulse", 32'(timeout), 32'd1);
        tick();
        chk("timeout_one_cycle", 32'(timeout), 32'd0);
`else
        chk("hold_cycles", 32'(n), 32'd20);
        chk("timeout_tied", 32'(timeout), 32'd0);
`endif
        req = 4'b0000;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum grant length in cycles when the timeout feature is compiled in (legal 2..255).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  4  request vector; bit i = requester i.
REQ-005 Port: done  input  1  current owner finished; sampled only while gnt_valid=1.
REQ-006 Port: gnt  output  4  one-hot grant vector (decoded form of gnt_id).
REQ-007 Port: gnt_id  output  2  binary index of current owner.
REQ-008 Port: gnt_valid  output  1  a grant is active.
REQ-009 Port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have two states, IDLE and GRANT; all outputs are registered.
REQ-011 A 2-bit priority pointer ptr SHALL select search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE with req!=0, the first set bit in pointer order SHALL be granted at the next edge: state->GRANT, gnt_id=index, gnt=1<<index, gnt_valid=1 (latency one cycle).
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0, gnt_valid=0, gnt_id held.
REQ-014 In GRANT, gnt/gnt_id SHALL stay constant while req[gnt_id]=1 and done=0.
REQ-015 In GRANT, done=1 or req[gnt_id]=0 SHALL release: next edge gnt=0, gnt_valid=0, state->IDLE, ptr=gnt_id+1 (2'b11 wraps to 2'b00).
REQ-016 After every release the block SHALL spend exactly one cycle in IDLE before the next grant (no back-to-back grant).
REQ-017 done in IDLE SHALL be ignored.
REQ-018 Requests from non-owners during GRANT SHALL neither preempt nor change ptr.
REQ-019 gnt SHALL always be zero or one-hot, and equal 1<<gnt_id whenever gnt_valid=1.
REQ-020 timeout SHALL be 0 except as defined in REQ-025.

Reset
REQ-021 rst=1 SHALL immediately, without a clock edge, force state=IDLE, ptr=0, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, timeout=0, hold counter=0.
REQ-022 Reset asserted mid-grant SHALL drop the grant at once; after deassertion the first grant uses ptr=0 (requester 0 highest).
REQ-023 The first rising edge after rst deasserts SHALL be a normal IDLE evaluation.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile the hold-limit feature in or out.
REQ-025 With ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on each grant and increment every GRANT cycle; when the grant has been held MAX_HOLD cycles without release, the next edge SHALL force release per REQ-015 and pulse timeout=1 for one cycle; a simultaneous done SHALL count as normal release (no timeout pulse).
REQ-026 Without ARB_TIMEOUT_EN: no counter SHALL exist, grants last indefinitely, and timeout SHALL be tied to 0; port list unchanged.

Verification
REQ-027 After reset, req=4'b1111, done pulsed 2 cycles after each grant -> gnt sequence 0001,0010,0100,1000,0001 with one idle cycle between grants.
REQ-028 ptr=2 (after owner 1 released), req=4'b0011 -> gnt_id=0 (wrap), then ptr=1.
REQ-029 Owner 1 holds, req[3] rises then done=1 -> gnt stays 0010 until release, then gnt=1000 after one idle cycle.
REQ-030 Owner 2 drops req[2] with done=0 -> gnt_valid=0 next edge, ptr=3.
REQ-031 rst asserted between edges while gnt=0100 -> gnt=0, gnt_valid=0 immediately; after release with req=4'b0101 -> gnt=0001.
REQ-032 ARB_TIMEOUT_EN, MAX_HOLD=8, req[0] held, done=0 -> gnt_valid high exactly 8 cycles, timeout pulses 1 cycle at release; without macro gnt persists and timeout stays 0.
